// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Optional watchdog abort of a stuck frame: define UART_ARB_WDOG_EN.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int WDOG_CYCLES = 12000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        wdog_err
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                tx_start_q, tx_start_d;
  logic                arb_busy_q, arb_busy_d;
  logic                wdog_err_q, wdog_err_d;
  logic [IDX_W-1:0]    winner;
  logic                found;
  int                  idx;

`ifdef UART_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic                wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
`endif

  // Search starts just after the last served requester, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    wdog_err_d = 1'b0;
`ifdef UART_ARB_WDOG_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          tx_data_d     = req_data[int'(winner)*DATA_W +: DATA_W];
          grant_d       = winner;
          ack_d[winner] = 1'b1;
          tx_start_d    = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        last_d  = grant_q;
        state_d = WAIT_DONE;
`ifdef UART_ARB_WDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
`ifdef UART_ARB_WDOG_EN
        end else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
          state_d    = IDLE;
          wdog_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      arb_busy_q <= 1'b0;
      wdog_err_q <= 1'b0;
`ifdef UART_ARB_WDOG_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      arb_busy_q <= arb_busy_d;
      wdog_err_q <= wdog_err_d;
`ifdef UART_ARB_WDOG_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign arb_busy = arb_busy_q;
  assign wdog_err = wdog_err_q;
endmodule
